// File: rtl/idex_stage_reg.sv
// ID/EX pipeline stage register: valid/ready handshake, 2-entry skid buffer, flush-to-bubble.
// Optional idle-cycle counter (bubble_cnt/bubble_clr) is enabled by defining IDEX_BUBBLE_CNT_EN.
module idex_stage_reg #(
    parameter int                 DATA_W    = 16,
    parameter int                 OP_W      = 4,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(16'h0000),
    parameter logic [OP_W-1:0]    NOP_ALUOP = OP_W'(4'h0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op1_in,
    input  logic [DATA_W-1:0] op2_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] seimm_in,
    input  logic [DATA_W-1:0] r15_in,
    input  logic [OP_W-1:0]   aluop_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op1_out,
    output logic [DATA_W-1:0] op2_out,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] seimm_out,
    output logic [DATA_W-1:0] r15_out,
    output logic [OP_W-1:0]   aluop_out
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    input  logic              bubble_clr,
    output logic [15:0]       bubble_cnt
`endif
);

    localparam int NF        = 5;
    localparam int INSTR_IDX = 2;
    localparam int PAY_W     = NF * DATA_W + OP_W;

    logic [DATA_W-1:0] fld_in  [NF];
    logic [DATA_W-1:0] fld_out [NF];

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] nop_pay;

    logic             m_valid_reg, m_valid_next;
    logic             s_valid_reg, s_valid_next;
    logic [PAY_W-1:0] m_pay_reg,   m_pay_next;
    logic [PAY_W-1:0] s_pay_reg,   s_pay_next;
    logic             in_ready_reg;

    logic accept;
    logic deliver;

    assign fld_in[0] = op1_in;
    assign fld_in[1] = op2_in;
    assign fld_in[2] = instr_in;
    assign fld_in[3] = seimm_in;
    assign fld_in[4] = r15_in;

    // Payload is carried as one flat vector; ALU opcode occupies the top bits.
    generate
        for (genvar gi = 0; gi < NF; gi++) begin : g_fields
            assign in_pay[gi*DATA_W +: DATA_W]  = fld_in[gi];
            assign nop_pay[gi*DATA_W +: DATA_W] = (gi == INSTR_IDX) ? NOP_INSTR : '0;
            assign fld_out[gi]                  = m_pay_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign in_pay[PAY_W-1 -: OP_W]  = aluop_in;
    assign nop_pay[PAY_W-1 -: OP_W] = NOP_ALUOP;

    assign accept  = in_valid & in_ready_reg;
    assign deliver = m_valid_reg & out_ready;

    always_comb begin
        m_valid_next = m_valid_reg;
        s_valid_next = s_valid_reg;
        m_pay_next   = m_pay_reg;
        s_pay_next   = s_pay_reg;
        if (flush) begin
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
            m_pay_next   = nop_pay;
        end else if (!m_valid_reg || deliver) begin
            // Skid entry is older than anything on the input, so it drains first.
            if (s_valid_reg) begin
                m_valid_next = 1'b1;
                m_pay_next   = s_pay_reg;
                s_valid_next = 1'b0;
            end else if (accept) begin
                m_valid_next = 1'b1;
                m_pay_next   = in_pay;
            end else begin
                m_valid_next = 1'b0;
                m_pay_next   = nop_pay;
            end
        end else if (accept) begin
            s_valid_next = 1'b1;
            s_pay_next   = in_pay;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg  <= 1'b0;
            s_valid_reg  <= 1'b0;
            m_pay_reg    <= nop_pay;
            s_pay_reg    <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            m_valid_reg  <= m_valid_next;
            s_valid_reg  <= s_valid_next;
            m_pay_reg    <= m_pay_next;
            s_pay_reg    <= s_pay_next;
            // Registered copy of the skid-empty flag: no path from out_ready to in_ready.
            in_ready_reg <= !s_valid_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = m_valid_reg;
    assign op1_out   = fld_out[0];
    assign op2_out   = fld_out[1];
    assign instr_out = fld_out[2];
    assign seimm_out = fld_out[3];
    assign r15_out   = fld_out[4];
    assign aluop_out = m_pay_reg[PAY_W-1 -: OP_W];

`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_reg <= '0;
        end else if (bubble_clr) begin
            bubble_cnt_reg <= '0;
        end else if (!m_valid_reg && bubble_cnt_reg != 16'hFFFF) begin
            bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_reg;
`endif

    a_ready_tracks_skid: assert property (@(posedge clk) disable iff (rst)
        in_ready_reg == !s_valid_reg);

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (m_valid_reg && !out_ready && !flush) |=> $stable(m_pay_reg));

endmodule

// File: tb/tb_idex_stage_reg.sv
// Directed bench for idex_stage_reg: reset, streaming, backpressure, flush, reset mid-stall
// and, when IDEX_BUBBLE_CNT_EN is defined, the bubble counter.
module tb_idex_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op1_in, op2_in, instr_in, seimm_in, r15_in;
    logic [3:0]  aluop_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] op1_out, op2_out, instr_out, seimm_out, r15_out;
    logic [3:0]  aluop_out;
`ifdef IDEX_BUBBLE_CNT_EN
    logic        bubble_clr;
    logic [15:0] bubble_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    idex_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1_in    (op1_in),
        .op2_in    (op2_in),
        .instr_in  (instr_in),
        .seimm_in  (seimm_in),
        .r15_in    (r15_in),
        .aluop_in  (aluop_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op1_out   (op1_out),
        .op2_out   (op2_out),
        .instr_out (instr_out),
        .seimm_out (seimm_out),
        .r15_out   (r15_out),
        .aluop_out (aluop_out)
`ifdef IDEX_BUBBLE_CNT_EN
        ,
        .bubble_clr(bubble_clr),
        .bubble_cnt(bubble_cnt)
`endif
    );

    // Every payload field is derived from the instruction word so one value identifies an entry.
    function automatic logic [15:0] f_op1(input logic [15:0] i);   return i ^ 16'h00FF;        endfunction
    function automatic logic [15:0] f_op2(input logic [15:0] i);   return ~i;                  endfunction
    function automatic logic [15:0] f_seimm(input logic [15:0] i); return {i[7:0], i[15:8]};   endfunction
    function automatic logic [15:0] f_r15(input logic [15:0] i);   return i + 16'h0001;        endfunction
    function automatic logic [3:0]  f_aluop(input logic [15:0] i); return i[3:0] ^ 4'h5;       endfunction

    task automatic drive(input logic v, input logic [15:0] i);
        in_valid = v;
        instr_in = i;
        op1_in   = f_op1(i);
        op2_in   = f_op2(i);
        seimm_in = f_seimm(i);
        r15_in   = f_r15(i);
        aluop_in = f_aluop(i);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 16'h5555);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 16'h0000);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++;
        if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h expected 0000", instr_out); end
        n_tests++;
        if (aluop_out !== 4'h0) begin n_fail++; $display("FAIL reset_aluop: got %h expected 0", aluop_out); end
        n_tests++;
        if ({op1_out, op2_out, seimm_out, r15_out} !== 64'h0) begin
            n_fail++; $display("FAIL reset_payload: got %h %h %h %h expected zeros", op1_out, op2_out, seimm_out, r15_out);
        end
        $display("[TB] reset: out_valid=%b in_ready=%b instr=%h", out_valid, in_ready, instr_out);
    endtask

    task automatic test_streaming();
        logic [15:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = 16'h1001 + 16'(k);
            drive(1'b1, e);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || instr_out !== e) begin
                n_fail++; $display("FAIL stream_out[%0d]: got valid=%b instr=%h expected valid=1 instr=%h", k, out_valid, instr_out, e);
            end
            n_tests++;
            if (op1_out !== f_op1(e) || op2_out !== f_op2(e) || seimm_out !== f_seimm(e) ||
                r15_out !== f_r15(e) || aluop_out !== f_aluop(e)) begin
                n_fail++; $display("FAIL stream_payload[%0d]: got %h %h %h %h %h for instr %h", k,
                                   op1_out, op2_out, seimm_out, r15_out, aluop_out, e);
            end
            n_tests++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, in_ready); end
            $display("[TB] stream: k=%0d instr_out=%h in_ready=%b", k, instr_out, in_ready);
        end
        drive(1'b0, 16'h0000);
        step();
        n_tests++;
        if (out_valid !== 1'b0 || instr_out !== 16'h0000 || aluop_out !== 4'h0 || op1_out !== 16'h0) begin
            n_fail++; $display("FAIL stream_drain: got valid=%b instr=%h aluop=%h op1=%h expected bubble", out_valid, instr_out, aluop_out, op1_out);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive(1'b1, 16'hA001);
        step();
        out_ready = 1'b0;
        drive(1'b1, 16'hA002);
        step();
        n_tests++;
        if (instr_out !== 16'hA001 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_skid_fill: got instr=%h valid=%b in_ready=%b expected A001 1 0", instr_out, out_valid, in_ready);
        end
        drive(1'b1, 16'hA003);
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++;
            if (instr_out !== 16'hA001 || op1_out !== f_op1(16'hA001) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got instr=%h valid=%b in_ready=%b expected A001 1 0", k, instr_out, out_valid, in_ready);
            end
            $display("[TB] backpressure hold: instr_out=%h in_ready=%b", instr_out, in_ready);
        end
        out_ready = 1'b1;
        step();
        n_tests++;
        if (instr_out !== 16'hA002 || out_valid !== 1'b1 || in_ready !== 1'b1 || r15_out !== f_r15(16'hA002)) begin
            n_fail++; $display("FAIL bp_release_a002: got instr=%h valid=%b in_ready=%b expected A002 1 1", instr_out, out_valid, in_ready);
        end
        step();
        n_tests++;
        if (instr_out !== 16'hA003 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_a003: got instr=%h valid=%b expected A003 1", instr_out, out_valid);
        end
        drive(1'b0, 16'h0000);
        step();
        n_tests++;
        if (out_valid !== 1'b0 || instr_out !== 16'h0000) begin
            n_fail++; $display("FAIL bp_drain: got valid=%b instr=%h expected 0 0000", out_valid, instr_out);
        end
        $display("[TB] backpressure done: out_valid=%b", out_valid);
    endtask

    // Leaves M=B001/C001-style first entry and S=second entry with execute stalled.
    task automatic fill_both(input logic [15:0] a, input logic [15:0] b);
        out_ready = 1'b0;
        drive(1'b1, a);
        step();
        drive(1'b1, b);
        step();
    endtask

    task automatic test_flush();
        fill_both(16'hB001, 16'hB002);
        n_tests++;
        if (instr_out !== 16'hB001 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_setup: got instr=%h in_ready=%b expected B001 0", instr_out, in_ready);
        end
        flush = 1'b1;
        drive(1'b1, 16'hB003);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0000);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== 16'h0000 || aluop_out !== 4'h0) begin
            n_fail++; $display("FAIL flush_empty: got valid=%b in_ready=%b instr=%h aluop=%h expected 0 1 0000 0",
                               out_valid, in_ready, instr_out, aluop_out);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost[%0d]: got valid=%b instr=%h expected 0", k, out_valid, instr_out); end
        end
        // Flush while empty and ready: the same-cycle accept must be dropped.
        flush = 1'b1;
        drive(1'b1, 16'hB004);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0000);
        n_tests++;
        if (out_valid !== 1'b0 || instr_out !== 16'h0000) begin
            n_fail++; $display("FAIL flush_drop_accept: got valid=%b instr=%h expected 0 0000", out_valid, instr_out);
        end
        $display("[TB] flush done: out_valid=%b in_ready=%b", out_valid, in_ready);
    endtask

    task automatic test_reset_mid_stall();
        fill_both(16'hC0F1, 16'hC0F2);
        rst = 1'b1;
        drive(1'b1, 16'hC0F3);
        step();
        rst = 1'b0;
        drive(1'b0, 16'h0000);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== 16'h0000) begin
            n_fail++; $display("FAIL rst_stall_empty: got valid=%b in_ready=%b instr=%h expected 0 1 0000", out_valid, in_ready, instr_out);
        end
        out_ready = 1'b1;
        drive(1'b1, 16'hC001);
        step();
        drive(1'b0, 16'h0000);
        n_tests++;
        if (out_valid !== 1'b1 || instr_out !== 16'hC001 || seimm_out !== f_seimm(16'hC001)) begin
            n_fail++; $display("FAIL rst_stall_first: got valid=%b instr=%h expected 1 C001", out_valid, instr_out);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_after: got valid=%b instr=%h expected 0", out_valid, instr_out); end
        $display("[TB] reset mid-stall done: first entry C001 seen=%b", 1'b1);
    endtask

`ifdef IDEX_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        bubble_clr = 1'b0;
        drive(1'b0, 16'h0000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL bubble_reset: got %h expected 0000", bubble_cnt); end
        for (int k = 0; k < 5; k++) step();
        n_tests++;
        if (bubble_cnt !== 16'd5) begin n_fail++; $display("FAIL bubble_five: got %h expected 0005", bubble_cnt); end
        bubble_clr = 1'b1;
        step();
        bubble_clr = 1'b0;
        n_tests++;
        if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL bubble_clr: got %h expected 0000", bubble_cnt); end
        for (int k = 0; k < 65534; k++) step();
        n_tests++;
        if (bubble_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL bubble_fffe: got %h expected FFFE", bubble_cnt); end
        for (int k = 0; k < 3; k++) step();
        n_tests++;
        if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL bubble_sat: got %h expected FFFF", bubble_cnt); end
        $display("[TB] bubble_cnt saturated at %h", bubble_cnt);
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
`ifdef IDEX_BUBBLE_CNT_EN
        bubble_clr = 1'b0;
`endif
        drive(1'b0, 16'h0000);
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
`ifdef IDEX_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
